// File: rtl/common_pkg.sv
// Shared NoC configuration defaults used by the link interface and endpoints.
package common_pkg;

  localparam int DEFAULT_VC_W    = 2;
  localparam int DEFAULT_X_W     = 4;
  localparam int DEFAULT_Y_W     = 4;
  localparam int DEFAULT_D_W     = 8;
  localparam int DEFAULT_CREDITS = 4;

  // Counter width able to hold every value from 0 up to and including max_credits.
  function automatic int credit_width(input int max_credits);
    return $clog2(max_credits + 1);
  endfunction

endpackage

// File: rtl/noc_if.sv
// NoC link: transmitter drives vc_target/packet, receiver returns per-VC credits.
interface noc_if
  import common_pkg::*;
#(
  parameter int VC_W = DEFAULT_VC_W,
  parameter int X_W  = DEFAULT_X_W,
  parameter int Y_W  = DEFAULT_Y_W,
  parameter int D_W  = DEFAULT_D_W
);

  typedef struct packed {
    logic [D_W-1:0] data;
  } payload_t;

  typedef struct packed {
    logic [X_W+Y_W-1:0] addr;
  } routeinfo_t;

  typedef struct packed {
    routeinfo_t routeinfo;
    payload_t   payload;
  } packet_t;

  logic [VC_W-1:0] vc_target;
  packet_t         packet;
  logic [VC_W-1:0] vc_credit_gnt;

  modport transmitter (output vc_target, output packet, input vc_credit_gnt);
  modport receiver    (input vc_target, input packet, output vc_credit_gnt);

endinterface

// File: rtl/noc_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr; ptr moves past the winner on advance.
module noc_rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] gnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] win;
  logic          found;

  always_comb begin
    int idx;
    idx   = 0;
    gnt   = '0;
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        win      = PW'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance && found) begin
      ptr <= (int'(win) == N - 1) ? '0 : PW'(win + 1'b1);
    end
  end

endmodule

// File: rtl/modport_link.sv
// Credit-based NoC transmit endpoint driving noc_if.transmitter.
// Build option: NOC_TX_CREDIT_BYPASS_EN lets a credit arriving this cycle make its VC eligible at once.
module modport_link
  import common_pkg::*;
#(
  parameter int VC_W    = DEFAULT_VC_W,
  parameter int X_W     = DEFAULT_X_W,
  parameter int Y_W     = DEFAULT_Y_W,
  parameter int D_W     = DEFAULT_D_W,
  parameter int CREDITS = DEFAULT_CREDITS
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [VC_W-1:0]               in_valid,
  output logic [VC_W-1:0]               in_ready,
  input  logic [VC_W-1:0][D_W-1:0]      in_data,
  input  logic [VC_W-1:0][X_W+Y_W-1:0]  in_addr,
  noc_if.transmitter                    tx
);

  localparam int CW = credit_width(CREDITS);
  localparam logic [CW-1:0] CREDIT_MAX = CW'(CREDITS);

  // Handshake: a packet moves on VC i in any cycle where in_valid[i] && in_ready[i];
  // in_ready never waits on in_valid of another VC and at most one bit is high.
  logic [VC_W-1:0][CW-1:0]  credit;
  logic [VC_W-1:0]          eligible;
  logic [VC_W-1:0]          gnt;
  logic [VC_W-1:0]          send;
  logic [D_W-1:0]           sel_data;
  logic [X_W+Y_W-1:0]       sel_addr;

  always_comb begin
    eligible = '0;
    for (int i = 0; i < VC_W; i++) begin
`ifdef NOC_TX_CREDIT_BYPASS_EN
      eligible[i] = in_valid[i] && ((credit[i] != '0) || tx.vc_credit_gnt[i]);
`else
      eligible[i] = in_valid[i] && (credit[i] != '0);
`endif
    end
  end

  noc_rr_arbiter #(.N(VC_W)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (eligible),
    .advance (|send),
    .gnt     (gnt)
  );

  assign in_ready = rst ? '0 : gnt;
  assign send     = in_ready & in_valid;

  always_comb begin
    sel_data = '0;
    sel_addr = '0;
    for (int i = 0; i < VC_W; i++) begin
      if (send[i]) begin
        sel_data = sel_data | in_data[i];
        sel_addr = sel_addr | in_addr[i];
      end
    end
  end

  // A returned credit and a send on the same VC cancel; a credit beyond CREDITS is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < VC_W; i++) credit[i] <= CREDIT_MAX;
    end else begin
      for (int i = 0; i < VC_W; i++) begin
        case ({tx.vc_credit_gnt[i], send[i]})
          2'b10: if (credit[i] != CREDIT_MAX) credit[i] <= credit[i] + 1'b1;
          2'b01: credit[i] <= credit[i] - 1'b1;
          default: credit[i] <= credit[i];
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx.vc_target <= '0;
      tx.packet    <= '0;
    end else begin
      tx.vc_target <= send;
      if (|send) begin
        tx.packet.payload.data   <= sel_data;
        tx.packet.routeinfo.addr <= sel_addr;
      end
    end
  end

`ifdef SIMULATION
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < VC_W; i++) begin
        assert (!(tx.vc_credit_gnt[i] && !send[i] && credit[i] == CREDIT_MAX))
          else $warning("credit overflow on vc %0d", i);
      end
    end
  end
`endif

endmodule

// File: tb/tb_modport_link.sv
// Directed bench for modport_link with VC_W=2, CREDITS=4; expectations are hand-derived.
module tb_modport_link;
  import common_pkg::*;

  localparam int VC_W = 2;
  localparam int X_W  = 4;
  localparam int Y_W  = 4;
  localparam int D_W  = 8;

  // clock / reset block
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [VC_W-1:0]              in_valid;
  logic [VC_W-1:0]              in_ready;
  logic [VC_W-1:0][D_W-1:0]     in_data;
  logic [VC_W-1:0][X_W+Y_W-1:0] in_addr;

  noc_if #(.VC_W(VC_W), .X_W(X_W), .Y_W(Y_W), .D_W(D_W)) tx_if ();

  modport_link #(
    .VC_W(VC_W), .X_W(X_W), .Y_W(Y_W), .D_W(D_W), .CREDITS(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_addr  (in_addr),
    .tx       (tx_if.transmitter)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [VC_W-1:0] exp_vc;

  initial begin
    rst = 1'b1;
    in_valid = '0;
    in_data  = '0;
    in_addr  = '0;
    tx_if.vc_credit_gnt = '0;
    repeat (3) step();

    // reset state
    in_valid = 2'b11;
    #1;
    check_eq("ready_in_reset", 32'(in_ready), 32'h0);
    check_eq("target_in_reset", 32'(tx_if.vc_target), 32'h0);
    in_valid = '0;
    rst = 1'b0;
    #1;
    check_eq("reset_target", 32'(tx_if.vc_target), 32'h0);
    check_eq("reset_ready", 32'(in_ready), 32'h0);
    check_eq("reset_credit0", 32'(dut.credit[0]), 32'd4);
    check_eq("reset_credit1", 32'(dut.credit[1]), 32'd4);

    // single-VC burst drains the four credits
    in_valid = 2'b01;
    for (int k = 0; k < 4; k++) begin
      in_data[0] = 8'h10 + 8'(k);
      in_addr[0] = 8'h30 + 8'(k);
      #1;
      check_eq("burst_ready", 32'(in_ready), 32'h1);
      step();
      check_eq("burst_target", 32'(tx_if.vc_target), 32'h1);
      check_eq("burst_data", 32'(tx_if.packet.payload.data), 32'h10 + 32'(k));
      check_eq("burst_addr", 32'(tx_if.packet.routeinfo.addr), 32'h30 + 32'(k));
    end
    #1;
    check_eq("exhaust_ready", 32'(in_ready), 32'h0);
    check_eq("exhaust_credit0", 32'(dut.credit[0]), 32'd0);
    step();
    check_eq("exhaust_target", 32'(tx_if.vc_target), 32'h0);
    check_eq("idle_data_hold", 32'(tx_if.packet.payload.data), 32'h13);
    for (int k = 0; k < 3; k++) begin
      step();
      check_eq("exhaust_ready_hold", 32'(in_ready), 32'h0);
    end

    // credit return
    in_data[0] = 8'h20;
    tx_if.vc_credit_gnt = 2'b01;
    #1;
`ifdef NOC_TX_CREDIT_BYPASS_EN
    check_eq("bypass_ready", 32'(in_ready), 32'h1);
    step();
    tx_if.vc_credit_gnt = '0;
    check_eq("return_target", 32'(tx_if.vc_target), 32'h1);
    check_eq("return_data", 32'(tx_if.packet.payload.data), 32'h20);
`else
    check_eq("nobypass_ready", 32'(in_ready), 32'h0);
    step();
    tx_if.vc_credit_gnt = '0;
    #1;
    check_eq("return_credit0", 32'(dut.credit[0]), 32'd1);
    check_eq("return_ready", 32'(in_ready), 32'h1);
    check_eq("return_target_early", 32'(tx_if.vc_target), 32'h0);
    step();
    check_eq("return_target", 32'(tx_if.vc_target), 32'h1);
    check_eq("return_data", 32'(tx_if.packet.payload.data), 32'h20);
`endif
    in_valid = '0;
    #1;
    check_eq("return_credit_used", 32'(dut.credit[0]), 32'd0);

    // data integrity on VC1, then drain VC1
    in_valid   = 2'b10;
    in_data[1] = 8'hA5;
    in_addr[1] = 8'h12;
    #1;
    check_eq("vc1_ready", 32'(in_ready), 32'h2);
    step();
    check_eq("vc1_target", 32'(tx_if.vc_target), 32'h2);
    check_eq("vc1_data", 32'(tx_if.packet.payload.data), 32'hA5);
    check_eq("vc1_addr", 32'(tx_if.packet.routeinfo.addr), 32'h12);
    repeat (3) step();
    in_valid = '0;
    #1;
    check_eq("drain_credit1", 32'(dut.credit[1]), 32'd0);

    // multi-bit credit return with both counters at zero
    tx_if.vc_credit_gnt = 2'b11;
    step();
    tx_if.vc_credit_gnt = '0;
    check_eq("multi_credit0", 32'(dut.credit[0]), 32'd1);
    check_eq("multi_credit1", 32'(dut.credit[1]), 32'd1);

    // send and credit return on VC0 in the same cycle
    in_valid = 2'b01;
    tx_if.vc_credit_gnt = 2'b01;
    #1;
    check_eq("same_cycle_ready", 32'(in_ready), 32'h1);
    step();
    tx_if.vc_credit_gnt = '0;
    in_valid = '0;
    check_eq("same_cycle_target", 32'(tx_if.vc_target), 32'h1);
    check_eq("same_cycle_credit0", 32'(dut.credit[0]), 32'd1);

    // pointer sits past VC0, so VC1 wins; then reset mid-operation
    in_valid = 2'b11;
    #1;
    check_eq("rr_after_vc0", 32'(in_ready), 32'h2);
    rst = 1'b1;
    #1;
    check_eq("midrst_ready", 32'(in_ready), 32'h0);
    step();
    rst = 1'b0;
    check_eq("midrst_target", 32'(tx_if.vc_target), 32'h0);
    check_eq("midrst_credit0", 32'(dut.credit[0]), 32'd4);
    check_eq("midrst_credit1", 32'(dut.credit[1]), 32'd4);

    // round robin with the sender's credit returned each cycle
    for (int k = 0; k < 4; k++) begin
      exp_vc = (k % 2 == 0) ? 2'b01 : 2'b10;
      #1;
      check_eq("rr_ready", 32'(in_ready), 32'(exp_vc));
      tx_if.vc_credit_gnt = exp_vc;
      step();
      check_eq("rr_target", 32'(tx_if.vc_target), 32'(exp_vc));
    end
    tx_if.vc_credit_gnt = '0;
    in_valid = '0;
    check_eq("rr_credit0", 32'(dut.credit[0]), 32'd4);
    check_eq("rr_credit1", 32'(dut.credit[1]), 32'd4);

    // credit return while full saturates
    tx_if.vc_credit_gnt = 2'b01;
    step();
    tx_if.vc_credit_gnt = '0;
    check_eq("overflow_credit0", 32'(dut.credit[0]), 32'd4);
    check_eq("overflow_target", 32'(tx_if.vc_target), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
